// File: rtl/apb_bridge_pkg.sv
// Shared types for the AHB-to-APB bridge controller: FSM state encoding and bus width defaults.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package apb_bridge_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int NSEL_DEF   = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } state_t;

    // True for the three APB ENABLE-phase states.
    function automatic logic is_enable_st(input state_t s);
        return (s == ST_RENABLE) || (s == ST_WENABLE) || (s == ST_WENABLEP);
    endfunction

endpackage

// File: rtl/apb_sel_pipe.sv
// Two-stage delay of the decoded peripheral select, tracking the AHB address pipeline registers.
// Latency: sel1 = tempsel delayed 1 accepted cycle, sel2 = delayed 2 accepted cycles.
// Backpressure: both stages freeze while en (h_readyout) is low, exactly like h_addr1/h_addr2.
// Ports: h_clk, h_reset (sync, active-high), en, tempsel in; sel1, sel2 out.
module apb_sel_pipe #(
    parameter int NSEL = 3
) (
    input  logic            h_clk,
    input  logic            h_reset,
    input  logic            en,
    input  logic [NSEL-1:0] tempsel,
    output logic [NSEL-1:0] sel1,
    output logic [NSEL-1:0] sel2
);

    always_ff @(posedge h_clk) begin
        if (h_reset) begin
            sel1 <= '0;
            sel2 <= '0;
        end else if (en) begin
            sel1 <= tempsel;
            sel2 <= sel1;
        end
    end

endmodule

// File: rtl/apb_bridge_ctrl.sv
// APB-side sequencer of the AHB-to-APB bridge: turns decoded AHB transfers into APB SETUP/ENABLE phases.
// Latency: read = SETUP + ENABLE (2 cycles); write = WWAIT + SETUP + ENABLE (3 cycles from address phase).
// Backpressure: h_readyout low during every SETUP phase (and, with APB_PREADY_EN, while p_ready is low in ENABLE).
// Ports: h_clk, h_reset, valid, h_write, writereg, h_addr/h_addr1/h_addr2, h_wdata/h_wdata1, tempsel,
//        p_rdata, p_ready in; h_readyout, h_rdata, p_sel, p_enable, p_write, p_addr, p_wdata out.
// Optional feature macro: APB_PREADY_EN (APB wait states via p_ready; ignored when undefined).
module apb_bridge_ctrl
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NSEL   = NSEL_DEF
) (
    input  logic              h_clk,
    input  logic              h_reset,
    input  logic              valid,
    input  logic              h_write,
    input  logic              writereg,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [ADDR_W-1:0] h_addr1,
    input  logic [ADDR_W-1:0] h_addr2,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic [DATA_W-1:0] h_wdata1,
    input  logic [NSEL-1:0]   tempsel,
    input  logic [DATA_W-1:0] p_rdata,
    input  logic              p_ready,
    output logic              h_readyout,
    output logic [DATA_W-1:0] h_rdata,
    output logic [NSEL-1:0]   p_sel,
    output logic              p_enable,
    output logic              p_write,
    output logic [ADDR_W-1:0] p_addr,
    output logic [DATA_W-1:0] p_wdata
);

    state_t          state;
    state_t          state_nxt;
    logic [NSEL-1:0] sel1;
    logic [NSEL-1:0] sel2;
    logic            readyout_q;
    logic            in_enable;
    logic            enable_done;   // current ENABLE phase completes at this edge

    assign in_enable = is_enable_st(state);

`ifdef APB_PREADY_EN
    assign enable_done = p_ready;
    // Stall AHB for exactly the cycles the peripheral inserts wait states.
    assign h_readyout  = readyout_q & ~(in_enable & ~p_ready);
`else
    logic unused_p_ready;
    assign unused_p_ready = p_ready;
    assign enable_done    = 1'b1;
    assign h_readyout     = readyout_q;
`endif

    // A malformed decode (no bit or several bits set) must not select any peripheral.
    function automatic logic [NSEL-1:0] sel_filter(input logic [NSEL-1:0] s);
        return $onehot(s) ? s : '0;
    endfunction

    function automatic state_t next_state(input state_t cur, input logic vld, input logic wr_now,
                                          input logic wr_reg, input logic done);
        state_t fresh;
        fresh = !vld ? ST_IDLE : (wr_now ? ST_WWAIT : ST_READ);
        case (cur)
            ST_IDLE:     return fresh;
            ST_WWAIT:    return vld ? ST_WRITEP : ST_WRITE;
            ST_READ:     return ST_RENABLE;
            ST_WRITEP:   return ST_WENABLEP;
            ST_WRITE:    return vld ? ST_WENABLEP : ST_WENABLE;
            ST_RENABLE:  return done ? fresh : cur;
            ST_WENABLE:  return done ? fresh : cur;
            // Pipelined write completes: next is the queued read or the next write.
            ST_WENABLEP: return !done ? cur : (!wr_reg ? ST_READ : (vld ? ST_WRITEP : ST_WRITE));
            default:     return ST_IDLE;
        endcase
    endfunction

    assign state_nxt = next_state(state, valid, h_write, writereg, enable_done);

    apb_sel_pipe #(.NSEL(NSEL)) u_sel_pipe (
        .h_clk   (h_clk),
        .h_reset (h_reset),
        .en      (h_readyout),
        .tempsel (tempsel),
        .sel1    (sel1),
        .sel2    (sel2)
    );

    // Outputs are registered from the state being entered.
    always_ff @(posedge h_clk) begin
        if (h_reset) begin
            state      <= ST_IDLE;
            p_sel      <= '0;
            p_enable   <= 1'b0;
            p_write    <= 1'b0;
            p_addr     <= '0;
            p_wdata    <= '0;
            h_rdata    <= '0;
            readyout_q <= 1'b1;
        end else begin
            state <= state_nxt;
            if ((state == ST_RENABLE) && enable_done) begin
                h_rdata <= p_rdata;
            end
            case (state_nxt)
                ST_READ: begin
                    p_sel      <= sel_filter(tempsel);
                    p_addr     <= h_addr;
                    p_write    <= 1'b0;
                    p_enable   <= 1'b0;
                    readyout_q <= 1'b0;
                end
                ST_WRITE: begin
                    p_sel      <= sel_filter(sel1);
                    p_addr     <= h_addr1;
                    p_wdata    <= h_wdata;
                    p_write    <= 1'b1;
                    p_enable   <= 1'b0;
                    readyout_q <= 1'b0;
                end
                ST_WRITEP: begin
                    p_sel      <= sel_filter(sel2);
                    p_addr     <= h_addr2;
                    p_wdata    <= h_wdata1;
                    p_write    <= 1'b1;
                    p_enable   <= 1'b0;
                    readyout_q <= 1'b0;
                end
                ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                    p_enable   <= 1'b1;
                    readyout_q <= 1'b1;
                end
                default: begin
                    // IDLE / WWAIT: deselect, keep last address and data on the bus.
                    p_sel      <= '0;
                    p_enable   <= 1'b0;
                    readyout_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Self-checking bench for apb_bridge_ctrl: directed scenarios followed by randomized cycles,
// all outputs compared every cycle against a behavioural model of the bridge's phase rules.
module tb_apb_bridge_ctrl;

    logic        h_clk;
    logic        h_reset;
    logic        valid;
    logic        h_write;
    logic        writereg;
    logic [31:0] h_addr, h_addr1, h_addr2;
    logic [31:0] h_wdata, h_wdata1;
    logic [2:0]  tempsel;
    logic [31:0] p_rdata;
    logic        p_ready;
    logic        h_readyout;
    logic [31:0] h_rdata;
    logic [2:0]  p_sel;
    logic        p_enable;
    logic        p_write;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;

    int errors = 0;
    int checks = 0;

    apb_bridge_ctrl dut (
        .h_clk      (h_clk),
        .h_reset    (h_reset),
        .valid      (valid),
        .h_write    (h_write),
        .writereg   (writereg),
        .h_addr     (h_addr),
        .h_addr1    (h_addr1),
        .h_addr2    (h_addr2),
        .h_wdata    (h_wdata),
        .h_wdata1   (h_wdata1),
        .tempsel    (tempsel),
        .p_rdata    (p_rdata),
        .p_ready    (p_ready),
        .h_readyout (h_readyout),
        .h_rdata    (h_rdata),
        .p_sel      (p_sel),
        .p_enable   (p_enable),
        .p_write    (p_write),
        .p_addr     (p_addr),
        .p_wdata    (p_wdata)
    );

    initial h_clk = 1'b0;
    always #5 h_clk = ~h_clk;

    // ---------------- behavioural model ----------------
    string       m_phase = "IDLE";
    logic [2:0]  m_sel1 = 0, m_sel2 = 0;   // select history of accepted address phases
    logic        m_rdy = 1;
    logic [2:0]  m_psel = 0;
    logic        m_pen = 0, m_pwr = 0;
    logic [31:0] m_paddr = 0, m_pwdata = 0, m_rdata = 0;

    function automatic bit is_en(input string s);
        return (s == "RENABLE") || (s == "WENABLE") || (s == "WENABLEP");
    endfunction

    function automatic logic [2:0] filt(input logic [2:0] s);
        if ($countones(s) == 1) return s;
        return 3'b000;
    endfunction

    function automatic logic exp_readyout();
`ifdef APB_PREADY_EN
        if (is_en(m_phase) && !p_ready) return 1'b0;
`endif
        return m_rdy;
    endfunction

    task automatic model_edge();
        string nxt;
        bit    go;
        logic  rdy_now;
        rdy_now = exp_readyout();
        if (h_reset) begin
            m_phase = "IDLE"; m_sel1 = 0; m_sel2 = 0; m_rdy = 1;
            m_psel = 0; m_pen = 0; m_pwr = 0; m_paddr = 0; m_pwdata = 0; m_rdata = 0;
            return;
        end
        go = 1;
`ifdef APB_PREADY_EN
        if (is_en(m_phase) && !p_ready) go = 0;
`endif
        if (m_phase == "RENABLE" && go) m_rdata = p_rdata;
        nxt = m_phase;
        if (!go) nxt = m_phase;
        else if (m_phase == "IDLE" || m_phase == "RENABLE" || m_phase == "WENABLE") begin
            if (!valid) nxt = "IDLE";
            else if (h_write) nxt = "WWAIT";
            else nxt = "READ";
        end
        else if (m_phase == "WWAIT")  nxt = valid ? "WRITEP" : "WRITE";
        else if (m_phase == "READ")   nxt = "RENABLE";
        else if (m_phase == "WRITEP") nxt = "WENABLEP";
        else if (m_phase == "WRITE")  nxt = valid ? "WENABLEP" : "WENABLE";
        else if (m_phase == "WENABLEP") begin
            if (!writereg) nxt = "READ";
            else if (valid) nxt = "WRITEP";
            else nxt = "WRITE";
        end
        if (nxt == "READ") begin
            m_psel = filt(tempsel); m_paddr = h_addr; m_pwr = 0; m_pen = 0; m_rdy = 0;
        end else if (nxt == "WRITE") begin
            m_psel = filt(m_sel1); m_paddr = h_addr1; m_pwdata = h_wdata; m_pwr = 1; m_pen = 0; m_rdy = 0;
        end else if (nxt == "WRITEP") begin
            m_psel = filt(m_sel2); m_paddr = h_addr2; m_pwdata = h_wdata1; m_pwr = 1; m_pen = 0; m_rdy = 0;
        end else if (is_en(nxt)) begin
            m_pen = 1; m_rdy = 1;
        end else begin
            m_psel = 0; m_pen = 0; m_rdy = 1;
        end
        if (rdy_now) begin
            m_sel2 = m_sel1;
            m_sel1 = tempsel;
        end
        m_phase = nxt;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge h_clk);
        model_edge();
        #1;
        chk("h_readyout", {31'b0, h_readyout}, {31'b0, exp_readyout()});
        chk("h_rdata",    h_rdata,             m_rdata);
        chk("p_sel",      {29'b0, p_sel},      {29'b0, m_psel});
        chk("p_enable",   {31'b0, p_enable},   {31'b0, m_pen});
        chk("p_write",    {31'b0, p_write},    {31'b0, m_pwr});
        chk("p_addr",     p_addr,              m_paddr);
        chk("p_wdata",    p_wdata,             m_pwdata);
    endtask

    task automatic drv(input logic v, input logic hw, input logic wr,
                       input logic [31:0] a, input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] wd, input logic [31:0] wd1,
                       input logic [2:0] ts, input logic [31:0] rd);
        valid = v; h_write = hw; writereg = wr;
        h_addr = a; h_addr1 = a1; h_addr2 = a2;
        h_wdata = wd; h_wdata1 = wd1; tempsel = ts; p_rdata = rd;
    endtask

    initial begin
        h_reset = 1'b1;
        p_ready = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);

        // reset state
        tick();
        chk("rst_readyout", {31'b0, h_readyout}, 32'd1);
        chk("rst_p_sel",    {29'b0, p_sel},      32'd0);
        chk("rst_p_addr",   p_addr,              32'd0);
        h_reset = 1'b0;

        // single read
        drv(1, 0, 0, 32'h8000_0010, 0, 0, 0, 0, 3'b001, 0);
        tick();
        chk("rd_setup_psel", {29'b0, p_sel}, 32'd1);
        chk("rd_setup_pen",  {31'b0, p_enable}, 32'd0);
        chk("rd_setup_addr", p_addr, 32'h8000_0010);
        chk("rd_setup_rdy",  {31'b0, h_readyout}, 32'd0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 32'hCAFE_F00D);
        tick();
        chk("rd_enable_pen", {31'b0, p_enable}, 32'd1);
        tick();
        chk("rd_hrdata", h_rdata, 32'hCAFE_F00D);
        chk("rd_idle_psel", {29'b0, p_sel}, 32'd0);

        // single write
        drv(1, 1, 0, 32'h8400_0004, 0, 0, 0, 0, 3'b010, 0);
        tick();
        chk("wr_wwait_rdy", {31'b0, h_readyout}, 32'd1);
        drv(0, 0, 1, 0, 32'h8400_0004, 0, 32'h1234_5678, 0, 3'b000, 0);
        tick();
        chk("wr_setup_psel",  {29'b0, p_sel}, 32'd2);
        chk("wr_setup_pwr",   {31'b0, p_write}, 32'd1);
        chk("wr_setup_addr",  p_addr, 32'h8400_0004);
        chk("wr_setup_wdata", p_wdata, 32'h1234_5678);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        tick();
        chk("wr_enable_pen", {31'b0, p_enable}, 32'd1);
        tick();
        chk("wr_idle_pen", {31'b0, p_enable}, 32'd0);

        // back-to-back writes, then a read
        drv(1, 1, 0, 32'h8000_0000, 0, 0, 0, 0, 3'b001, 0);
        tick();
        drv(1, 1, 1, 32'h8000_0004, 32'h8000_0000, 32'h8000_0000, 32'hAAAA_0000, 32'hAAAA_0000, 3'b001, 0);
        tick();
        chk("b2b_p0_addr", p_addr, 32'h8000_0000);
        chk("b2b_p0_rdy",  {31'b0, h_readyout}, 32'd0);
        tick();
        chk("b2b_e0_pen",  {31'b0, p_enable}, 32'd1);
        drv(1, 1, 1, 32'h8000_0008, 32'h8000_0004, 32'h8000_0004, 32'hBBBB_0000, 32'hBBBB_0000, 3'b001, 0);
        tick();
        chk("b2b_p1_addr", p_addr, 32'h8000_0004);
        chk("b2b_p1_rdy",  {31'b0, h_readyout}, 32'd0);
        tick();
        chk("b2b_e1_pen",  {31'b0, p_enable}, 32'd1);
        drv(1, 0, 0, 32'h8800_0008, 0, 0, 0, 0, 3'b100, 0);
        tick();
        chk("wtr_psel", {29'b0, p_sel}, 32'd4);
        chk("wtr_pwr",  {31'b0, p_write}, 32'd0);
        chk("wtr_addr", p_addr, 32'h8800_0008);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 32'h5A5A_0001);
        tick();

        // reset during RENABLE aborts without capturing read data
        h_reset = 1'b1;
        tick();
        chk("abort_hrdata", h_rdata, 32'd0);
        chk("abort_pen",    {31'b0, p_enable}, 32'd0);
        chk("abort_rdy",    {31'b0, h_readyout}, 32'd1);
        chk("abort_addr",   p_addr, 32'd0);
        h_reset = 1'b0;

        // non-one-hot select reaches no peripheral
        drv(1, 0, 0, 32'h8C00_0000, 0, 0, 0, 0, 3'b011, 0);
        tick();
        chk("bad_sel_psel", {29'b0, p_sel}, 32'd0);
        chk("bad_sel_rdy",  {31'b0, h_readyout}, 32'd0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        tick();
        tick();

`ifdef APB_PREADY_EN
        // wait states in WENABLE
        drv(1, 1, 0, 32'h8400_0010, 0, 0, 0, 0, 3'b010, 0);
        tick();
        drv(0, 0, 1, 0, 32'h8400_0010, 0, 32'h0BAD_0001, 0, 3'b000, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        p_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_pen", {31'b0, p_enable}, 32'd1);
            chk("wait_rdy", {31'b0, h_readyout}, 32'd0);
        end
        p_ready = 1'b1;
        tick();
        chk("wait_exit_pen", {31'b0, p_enable}, 32'd0);
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            h_reset  = ($urandom_range(0, 199) == 0);
            valid    = 1'($urandom);
            h_write  = 1'($urandom);
            writereg = 1'($urandom);
            h_addr   = $urandom; h_addr1 = $urandom; h_addr2 = $urandom;
            h_wdata  = $urandom; h_wdata1 = $urandom; p_rdata = $urandom;
            r = int'($urandom_range(0, 4));
            if (r == 0)      tempsel = 3'b001;
            else if (r == 1) tempsel = 3'b010;
            else if (r == 2) tempsel = 3'b100;
            else             tempsel = 3'($urandom);
`ifdef APB_PREADY_EN
            p_ready = ($urandom_range(0, 2) != 0);
`endif
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
